draw_score_bcd: RTL and testbench

DRAW_SCORE_BCD -- requirements
Module: draw_score_bcd

---
 rtl/game_pkg.sv | 30 +++
 rtl/draw_score_bcd_bcd_counter.sv | 45 ++++
 rtl/draw_score_bcd.sv | 147 ++++++++++++++
 tb/tb_draw_score_bcd.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-wide encodings, sprite ROM layout constants and BCD helpers.
package game_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_RUN  = 2'b01,
    GS_OVER = 2'b10
  } game_state_e;

  localparam int NUM_BASE_ADDR    = 168215;
  localparam int DIGIT_W_PX       = 18;
  localparam int DIGIT_H_PX       = 21;
  localparam int PREFIX_BASE_ADDR = 84217;
  localparam int PREFIX_W_PX      = 38;
  localparam int PREFIX_X_PX      = 340;

  // Single-digit BCD add of a carry-in; returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
    logic [4:0] r;
    if (!cin) begin
      r = {1'b0, d};
    end else if (d == 4'd9) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/draw_score_bcd_bcd_counter.sv
// Multi-digit BCD counter with ripple carry, wrap to zero, clear and load.
module bcd_counter
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = 5
) (
  input  logic                    Clk50,
  input  logic                    Reset,
  input  logic                    inc,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] value
);

  logic [4*NUM_DIGITS-1:0] next_s;

  // Ripple the increment carry from the least significant digit upward.
  always_comb begin : ripple
    logic       c;
    logic [4:0] r;
    c      = inc;
    r      = 5'd0;
    next_s = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r                = bcd_digit_inc(value[4*i +: 4], c);
      next_s[4*i +: 4] = r[3:0];
      c                = r[4];
    end
  end

  // Clear beats load beats increment; the final carry is dropped so all-9s wraps.
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else begin
      value <= next_s;
    end
  end

endmodule

// File: rtl/draw_score_bcd.sv
// Score keeping (current/high BCD scores, milestone blink) and sprite hit test
// for the score row, with one registered cycle from WriteX/WriteY to outputs.
module draw_score_bcd
  import game_pkg::*;
#(
  parameter int NUM_DIGITS     = 5,
  parameter int LOC_X          = 380,
  parameter int LOC_Y          = 20,
  parameter int PITCH          = 20,
  parameter int DIGIT_W        = DIGIT_W_PX,
  parameter int DIGIT_H        = DIGIT_H_PX,
  parameter int NUM_BASE       = NUM_BASE_ADDR,
  parameter int PREFIX_EN      = 1,
  parameter int PREFIX_BASE    = PREFIX_BASE_ADDR,
  parameter int PREFIX_W       = PREFIX_W_PX,
  parameter int PREFIX_X       = PREFIX_X_PX,
  parameter int FRAMES_PER_INC = 10,
  parameter int BLINK_FRAMES   = 60
) (
  input  logic                    Clk50,
  input  logic                    Reset,
  input  logic                    frame_tick,
  input  logic [1:0]              Game_State,
  input  logic                    Dead,
  input  logic                    show_hi,
  input  logic [9:0]              WriteX,
  input  logic [9:0]              WriteY,
  output logic [2:0]              score_on_wr,
  output logic [17:0]             address,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] hscore_bcd
);

  localparam int SW    = 4 * NUM_DIGITS;
  localparam int LOW_W = (NUM_DIGITS >= 2) ? 8 : 4;
  localparam logic [7:0] NINES = 8'h99;

  logic [1:0]    prev_state_r;
  logic          death_prev_r;
  logic [7:0]    frame_cnt_r;
  logic [7:0]    blink_r;
  logic          start_s, run_s, inc_s, milestone_s, death_s, death_rise_s, suppress_s;
  logic [SW-1:0] sel_s;
  logic          found_s, y_in_s;
  logic [3:0]    digit_s;
  logic [2:0]    on_s;
  int            addr_i, wx_i, wy_i, bx_i;

  assign start_s      = (Game_State == GS_RUN) && (prev_state_r == GS_IDLE);
  assign run_s        = (Game_State == GS_RUN) && !Dead;
  assign inc_s        = run_s && frame_tick && (frame_cnt_r == 8'(FRAMES_PER_INC));
  assign milestone_s  = inc_s && !start_s && (score_bcd[LOW_W-1:0] == NINES[LOW_W-1:0]);
  assign death_s      = Dead || (Game_State == GS_OVER);
  assign death_rise_s = death_s && !death_prev_r;
  assign suppress_s   = (blink_r != 8'd0) && !show_hi && blink_r[3];
  assign sel_s        = show_hi ? hscore_bcd : score_bcd;

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS)) u_score (
    .Clk50    (Clk50),
    .Reset    (Reset),
    .inc      (inc_s),
    .clr      (start_s),
    .load     (1'b0),
    .load_val ({SW{1'b0}}),
    .value    (score_bcd)
  );

  // Game-state edge detectors, frame pacing, milestone blink and high score.
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      prev_state_r <= GS_IDLE;
      death_prev_r <= 1'b0;
      frame_cnt_r  <= 8'd1;
      blink_r      <= 8'd0;
      hscore_bcd   <= '0;
    end else begin
      prev_state_r <= Game_State;
      death_prev_r <= death_s;
      if (start_s) begin
        frame_cnt_r <= 8'd1;
      end else if (run_s && frame_tick) begin
        frame_cnt_r <= (frame_cnt_r == 8'(FRAMES_PER_INC)) ? 8'd1 : frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (milestone_s) begin
        blink_r <= 8'(BLINK_FRAMES);
      end else if (frame_tick && (blink_r != 8'd0)) begin
        blink_r <= blink_r - 8'd1;
      end else begin
        blink_r <= blink_r;
      end
      // BCD packs in decimal order, so a plain unsigned compare ranks scores.
      if (death_rise_s && (score_bcd > hscore_bcd)) begin
        hscore_bcd <= score_bcd;
      end else begin
        hscore_bcd <= hscore_bcd;
      end
    end
  end

  assign wx_i   = int'(WriteX);
  assign wy_i   = int'(WriteY);
  assign y_in_s = (wy_i >= LOC_Y) && (wy_i < LOC_Y + DIGIT_H);

  // Pixel hit test: lowest digit wins, prefix only where no digit box hits.
  always_comb begin
    on_s    = 3'd0;
    addr_i  = 0;
    found_s = 1'b0;
    digit_s = 4'd0;
    bx_i    = 0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      if (!found_s && y_in_s && (wx_i >= LOC_X + (k-1)*PITCH) &&
          (wx_i < LOC_X + (k-1)*PITCH + DIGIT_W)) begin
        found_s = 1'b1;
        bx_i    = LOC_X + (k-1)*PITCH;
        on_s    = 3'(k);
        digit_s = sel_s[4*(NUM_DIGITS-k) +: 4];
        addr_i  = NUM_BASE + int'(digit_s)*DIGIT_W*DIGIT_H + (wy_i - LOC_Y)*DIGIT_W + (wx_i - bx_i);
      end else begin
        found_s = found_s;
      end
    end
    if (!found_s && (PREFIX_EN != 0) && y_in_s && (wx_i >= PREFIX_X) && (wx_i < PREFIX_X + PREFIX_W)) begin
      on_s   = 3'd7;
      addr_i = PREFIX_BASE + (wy_i - LOC_Y)*PREFIX_W + (wx_i - PREFIX_X);
    end else if (found_s && suppress_s) begin
      on_s   = 3'd0;
      addr_i = 0;
    end else begin
      on_s = on_s;
    end
  end

  // Output register: fixed one-cycle latency from the pixel coordinates.
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      score_on_wr <= 3'd0;
      address     <= 18'd0;
    end else begin
      score_on_wr <= on_s;
      address     <= 18'(addr_i);
    end
  end

endmodule

// File: tb/tb_draw_score_bcd.sv
// Directed bench: slow instance checks pacing/reset, fast instance checks
// high score, blink and hit test, standalone counter checks wrap behaviour.
module tb_draw_score_bcd;

  localparam int B  = 168215;
  localparam int PB = 84217;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, ft_a, dead_a, sh_a;
  logic [1:0]  gs_a;
  logic [2:0]  on_a;
  logic [17:0] addr_a;
  logic [19:0] sc_a, hs_a;

  logic        rst_b, ft_b, dead_b, sh_b;
  logic [1:0]  gs_b;
  logic [2:0]  on_b;
  logic [17:0] addr_b;
  logic [19:0] sc_b, hs_b;

  logic [9:0]  wx, wy;

  logic        c_rst, c_inc, c_clr, c_load;
  logic [19:0] c_val, c_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  draw_score_bcd dut (
    .Clk50(clk), .Reset(rst_a), .frame_tick(ft_a), .Game_State(gs_a), .Dead(dead_a),
    .show_hi(sh_a), .WriteX(wx), .WriteY(wy), .score_on_wr(on_a), .address(addr_a),
    .score_bcd(sc_a), .hscore_bcd(hs_a));

  draw_score_bcd #(.FRAMES_PER_INC(1)) dutf (
    .Clk50(clk), .Reset(rst_b), .frame_tick(ft_b), .Game_State(gs_b), .Dead(dead_b),
    .show_hi(sh_b), .WriteX(wx), .WriteY(wy), .score_on_wr(on_b), .address(addr_b),
    .score_bcd(sc_b), .hscore_bcd(hs_b));

  bcd_counter #(.NUM_DIGITS(5)) u_cnt (
    .Clk50(clk), .Reset(c_rst), .inc(c_inc), .clr(c_clr), .load(c_load),
    .load_val(c_val), .value(c_out));

  typedef struct {
    int         x;
    int         y;
    logic [2:0] on;
    int         addr;
  } hit_vec_t;

  hit_vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick_a(input int n);
    repeat (n) begin
      @(negedge clk) ft_a = 1'b1;
      @(negedge clk) ft_a = 1'b0;
    end
  endtask

  task automatic ticks_b(input int n);
    @(negedge clk) ft_b = 1'b1;
    repeat (n) @(negedge clk);
    ft_b = 1'b0;
  endtask

  task automatic pix_b(input int x, input int y);
    @(negedge clk);
    wx = 10'(x);
    wy = 10'(y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{400, 20, 3'd2, B + 4*378};
    vecs[1]  = '{357, 40, 3'd7, PB + 20*38 + 17};
    vecs[2]  = '{380, 20, 3'd1, B};
    vecs[3]  = '{417, 40, 3'd2, B + 4*378 + 20*18 + 17};
    vecs[4]  = '{418, 20, 3'd0, 0};
    vecs[5]  = '{425, 30, 3'd3, B + 2*378 + 10*18 + 5};
    vecs[6]  = '{440, 22, 3'd4, B + 7*378 + 2*18};
    vecs[7]  = '{477, 40, 3'd5, B + 378 + 20*18 + 17};
    vecs[8]  = '{478, 25, 3'd0, 0};
    vecs[9]  = '{377, 20, 3'd7, PB + 37};
    vecs[10] = '{340, 20, 3'd7, PB};
    vecs[11] = '{339, 20, 3'd0, 0};
    vecs[12] = '{400, 19, 3'd0, 0};
    vecs[13] = '{400, 41, 3'd0, 0};

    rst_a = 1'b1; ft_a = 1'b0; dead_a = 1'b0; sh_a = 1'b0; gs_a = 2'b00;
    rst_b = 1'b1; ft_b = 1'b0; dead_b = 1'b0; sh_b = 1'b0; gs_b = 2'b00;
    c_rst = 1'b1; c_inc = 1'b0; c_clr = 1'b0; c_load = 1'b0; c_val = 20'h0;
    wx = 10'd0; wy = 10'd0;
    repeat (2) @(negedge clk);
    chk("reset_score", 32'(sc_a), 32'h0);
    chk("reset_hscore", 32'(hs_a), 32'h0);
    chk("reset_on", 32'(on_a), 32'h0);
    chk("reset_addr", 32'(addr_a), 32'h0);
    chk("reset_frame_cnt", 32'(dut.frame_cnt_r), 32'd1);
    chk("reset_blink", 32'(dutf.blink_r), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; c_rst = 1'b0;

    // Standalone counter: carry ripple and wrap.
    @(negedge clk) begin c_load = 1'b1; c_val = 20'h09999; end
    @(negedge clk) begin c_load = 1'b0; c_inc = 1'b1; end
    @(negedge clk) c_inc = 1'b0;
    chk("cnt_09999_inc", 32'(c_out), 32'h10000);
    @(negedge clk) begin c_load = 1'b1; c_val = 20'h99999; end
    @(negedge clk) begin c_load = 1'b0; c_inc = 1'b1; end
    @(negedge clk) c_inc = 1'b1;
    chk("cnt_99999_wrap", 32'(c_out), 32'h00000);
    @(negedge clk) c_inc = 1'b0;
    chk("cnt_after_wrap", 32'(c_out), 32'h00001);
    @(negedge clk) c_clr = 1'b1;
    @(negedge clk) c_clr = 1'b0;
    chk("cnt_clear", 32'(c_out), 32'h00000);

    // Slow instance: pacing, mid-frame reset, restart latency.
    @(negedge clk) gs_a = 2'b01;
    @(negedge clk);
    tick_a(30);
    chk("a_score_30_ticks", 32'(sc_a), 32'h00003);
    chk("a_hscore_30_ticks", 32'(hs_a), 32'h00000);
    tick_a(8);
    chk("a_frame_cnt_9", 32'(dut.frame_cnt_r), 32'd9);
    #2 rst_a = 1'b1;
    #1;
    chk("a_midframe_cnt", 32'(dut.frame_cnt_r), 32'd1);
    chk("a_midframe_score", 32'(sc_a), 32'h0);
    gs_a = 2'b00;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk) gs_a = 2'b01;
    @(negedge clk);
    tick_a(9);
    chk("a_9_ticks_after_restart", 32'(sc_a), 32'h0);
    tick_a(1);
    chk("a_10th_tick_incr", 32'(sc_a), 32'h1);

    // Fast instance: high score capture and retention.
    @(negedge clk) gs_b = 2'b01;
    @(negedge clk);
    ticks_b(100);
    chk("b_score_100", 32'(sc_b), 32'h00100);
    dead_b = 1'b1;
    @(negedge clk);
    chk("b_hscore_100", 32'(hs_b), 32'h00100);
    dead_b = 1'b0; gs_b = 2'b00;
    @(negedge clk) gs_b = 2'b01;
    @(negedge clk);
    ticks_b(123);
    chk("b_score_123", 32'(sc_b), 32'h00123);
    dead_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_hscore_123", 32'(hs_b), 32'h00123);
    ticks_b(50);
    chk("b_dead_held_score", 32'(sc_b), 32'h00123);
    chk("b_dead_held_hscore", 32'(hs_b), 32'h00123);
    dead_b = 1'b0; gs_b = 2'b00;
    @(negedge clk) gs_b = 2'b01;
    @(negedge clk);
    chk("b_restart_score", 32'(sc_b), 32'h0);
    chk("b_restart_hscore", 32'(hs_b), 32'h00123);

    // Milestone blink at 200.
    ticks_b(200);
    gs_b = 2'b00;
    chk("b_score_200", 32'(sc_b), 32'h00200);
    chk("b_blink_loaded", 32'(dutf.blink_r), 32'd60);
    pix_b(442, 25);
    chk("b_blink60_on", 32'(on_b), 32'd0);
    chk("b_blink60_addr", 32'(addr_b), 32'd0);
    @(negedge clk) sh_b = 1'b1;
    @(posedge clk) #1;
    chk("b_showhi_on", 32'(on_b), 32'd4);
    chk("b_showhi_addr", 32'(addr_b), 32'(B + 2*378 + 92));
    @(negedge clk) sh_b = 1'b0;
    ticks_b(5);
    @(posedge clk) #1;
    chk("b_blink55_on", 32'(on_b), 32'd4);
    chk("b_blink55_addr", 32'(addr_b), 32'(B + 92));
    ticks_b(8);
    @(posedge clk) #1;
    chk("b_blink47_on", 32'(on_b), 32'd0);
    ticks_b(47);
    @(posedge clk) #1;
    chk("b_blink0_on", 32'(on_b), 32'd4);

    // Hit-test table at score 04271.
    @(negedge clk) gs_b = 2'b01;
    @(negedge clk);
    ticks_b(4271);
    gs_b = 2'b00;
    chk("b_score_4271", 32'(sc_b), 32'h04271);
    for (int i = 0; i < 14; i++) begin
      pix_b(vecs[i].x, vecs[i].y);
      chk($sformatf("hit_on[%0d]", i), 32'(on_b), 32'(vecs[i].on));
      chk($sformatf("hit_addr[%0d]", i), 32'(addr_b), 32'(vecs[i].addr));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
